n4_b2_counter_sched: RTL
========================

Name: n4_b2_counter_sched

Overview:
- Round-robin scheduler that shares one n4_b2_counter between two requesters.
- Each requester asks for a timed interval of D counter ticks. The scheduler grants one requester, drives the counter's ei for exactly D cycles, then completes a 4-phase req/ack handshake.
- Sits between the requesters and the counter. The counter has no clear, so the scheduler runs relative to the current count (target = start + D mod 16).

Parameters:
- WIDTH, 4: counter width; must match the counter's q3_q0 width.
- IDLE_GAP, 0: idle cycles enforced in IDLE after each ack before the next grant (0..7).

Ports:
- m_clock  input  1  system clock, rising edge
- m_reset_  input  1  asynchronous active-low reset
- req0  input  1  requester 0 request, 4-phase
- dur0  input  WIDTH  requester 0 duration in ticks; sampled at grant
- req1  input  1  requester 1 request, 4-phase
- dur1  input  WIDTH  requester 1 duration in ticks; sampled at grant
- ack0  output  1  requester 0 done
- ack1  output  1  requester 1 done
- gnt  output  2  one-hot current owner (00 = none)
- busy  output  1  high in ARM or RUN
- cnt_ei  output  1  enable to counter m_ei
- cnt_q  input  WIDTH  counter q3_q0
- cnt_eu  input  1  counter eu; used only for the wrap flag

Behaviour:
- Clock and reset: single clock m_clock. m_reset_ is asynchronous and active low.
- Reset values: state=IDLE, gnt=00, ack0=ack1=0, busy=0, cnt_ei=0, rr_last=1 (requester 0 wins first), gap counter=IDLE_GAP, wrap=0.
- States: IDLE, ARM, RUN, ACK.
- IDLE:
  - Gap counter decrements to 0 first.
  - Then, if any req is high, pick the owner (round-robin: the requester not equal to rr_last wins a tie; a lone requester always wins).
  - Set gnt and go to ARM.
- ARM (1 cycle):
  - Latch dur = dur[owner] and target = cnt_q + dur (mod 2^WIDTH, carry discarded).
  - Go to RUN.
- RUN:
  - cnt_ei = (cnt_q != target), combinational.
  - When cnt_q == target: cnt_ei=0 in that same cycle; go to ACK next edge.
  - Result: cnt_ei is high for exactly dur cycles. dur=0 gives zero ei cycles: RUN lasts 1 cycle.
- ACK:
  - ack[owner]=1 while req[owner]=1.
  - When req[owner]=0: ack drops next edge, gnt=00, rr_last=owner, gap counter reload=IDLE_GAP, go to IDLE.
- Latency: req high with the scheduler idle and IDLE_GAP=0 → gnt at edge 1, ARM at 1, RUN at 2, ack at edge 3+dur.
- Req dropped early (before ack): the run still completes. ACK sees req=0, asserts ack for exactly 1 cycle, then returns to IDLE.
- Non-owner req: ignored until the owner finishes. dur of the non-owner may change freely.
- dur change after ARM: no effect.
- Wrap-around: target may be less than start; the compare is equality only, so a wrap through 15→0 is handled.
- wrap (internal): set if cnt_eu is seen while cnt_ei=1 in RUN; cleared in ARM; exported only under the optional feature.
- Reset mid-run: immediate return to reset values. cnt_ei drops asynchronously. The counter value is not restored.
- Simultaneous requests: never both gnt bits high; never both acks high.

Optional Feature:
- Macro: N4_B2_COUNTER_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins ties and rr_last is ignored.
- Undefined: round-robin as above.

Test Plan:
- Reset, then req0=1, dur0=5, cnt_q=3 → gnt=01 at edge 1; cnt_ei high 5 cycles; cnt_q=8; ack0=1 at edge 8; drop req0 → ack0=0 and gnt=00 next edge.
- Wrap: cnt_q=14, req1=1, dur1=4 → target=2; cnt_ei high 4 cycles through 15,0,1; ack1 asserted; no double ack.
- Tie: req0=req1=1 held, dur=2 each, requester drops req after each ack and re-raises it → grant order 0,1,0,1 (FIXED_PRIO_EN: 0,0,0).
- dur0=0 → cnt_ei never high; ack0 at edge 3 after req.
- Early drop: req0 dropped during RUN (dur0=6) → run finishes 6 ticks; ack0 high exactly 1 cycle; then IDLE.
- Async reset mid-RUN (m_reset_=0 between edges) → cnt_ei, gnt, busy 0 immediately; after release with req1 only, requester 1 is granted. With IDLE_GAP=3, next grant comes 3 cycles after ack drops.

Source files
------------

// File: rtl/n4_b2_counter_sched.sv
// Shares one n4_b2_counter between two 4-phase requesters; each owner gets cnt_ei for dur ticks.
// Optional N4_B2_COUNTER_SCHED_FIXED_PRIO_EN: fixed priority to requester 0 and a wrap output.
module n4_b2_counter_sched #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned IDLE_GAP = 0
) (
  input  logic             m_clock,
  input  logic             m_reset_,
  input  logic             req0,
  input  logic [WIDTH-1:0] dur0,
  input  logic             req1,
  input  logic [WIDTH-1:0] dur1,
  output logic             ack0,
  output logic             ack1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             cnt_ei,
  input  logic [WIDTH-1:0] cnt_q,
  input  logic             cnt_eu
`ifdef N4_B2_COUNTER_SCHED_FIXED_PRIO_EN
  ,
  output logic             wrap
`endif
);

  typedef enum logic [1:0] {StIdle, StArm, StRun, StAck} state_e;

  localparam logic [2:0] GapInit = 3'(IDLE_GAP);

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             rr_last_q, rr_last_d;
  logic [2:0]       gap_q, gap_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             wrap_q, wrap_d;

  logic             pick1;
  logic             owner_req;
  logic [WIDTH-1:0] owner_dur;
  logic             at_target;

`ifdef N4_B2_COUNTER_SCHED_FIXED_PRIO_EN
  assign pick1 = req1 & ~req0;
  assign wrap  = wrap_q;
  logic unused_rr_last;
  assign unused_rr_last = rr_last_q;
`else
  // On a tie the requester that did not finish last wins.
  assign pick1 = req1 & (~req0 | ~rr_last_q);
  logic unused_wrap;
  assign unused_wrap = wrap_q;
`endif

  assign owner_req = gnt_q[1] ? req1 : req0;
  assign owner_dur = gnt_q[1] ? dur1 : dur0;
  assign at_target = (cnt_q == target_q);

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    rr_last_d = rr_last_q;
    gap_d     = gap_q;
    target_d  = target_q;
    wrap_d    = wrap_q;
    cnt_ei    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (gap_q != 3'd0) begin
          gap_d = gap_q - 3'd1;
        end else if (req0 || req1) begin
          gnt_d   = pick1 ? 2'b10 : 2'b01;
          state_d = StArm;
        end
      end
      StArm: begin
        // The counter cannot be cleared, so run relative to its current value.
        target_d = cnt_q + owner_dur;
        wrap_d   = 1'b0;
        state_d  = StRun;
      end
      StRun: begin
        cnt_ei = ~at_target;
        if (cnt_eu && cnt_ei) begin
          wrap_d = 1'b1;
        end
        if (at_target) begin
          state_d = StAck;
        end
      end
      StAck: begin
        if (!owner_req) begin
          gnt_d     = 2'b00;
          rr_last_d = gnt_q[1];
          gap_d     = GapInit;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge m_clock or negedge m_reset_) begin
    if (!m_reset_) begin
      state_q   <= StIdle;
      gnt_q     <= 2'b00;
      rr_last_q <= 1'b1;
      gap_q     <= GapInit;
      target_q  <= '0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      rr_last_q <= rr_last_d;
      gap_q     <= gap_d;
      target_q  <= target_d;
      wrap_q    <= wrap_d;
    end
  end

  assign gnt  = gnt_q;
  assign ack0 = (state_q == StAck) & gnt_q[0];
  assign ack1 = (state_q == StAck) & gnt_q[1];
  assign busy = (state_q == StArm) | (state_q == StRun);

endmodule
